// File: rtl/matrix_skew_feeder.sv
// ---------------------------------------------------------------------------
// matrix_skew_feeder
//
// Purpose:
//   Takes one PARALLEL_NUM-wide row per accepted beat and delays lane i by i
//   extra cycles. This produces the diagonal wavefront that a systolic MAC
//   array consumes.
//
//   Rows are grouped into tiles of INTER_NUM beats. After the last beat of a
//   tile the block drains the skew chains. It then pulses tile_done in the
//   cycle the tile's last element leaves lane PARALLEL_NUM-1.
//
//   There is no downstream backpressure.
//
// Handshake:
//   A beat transfers on a rising clk edge where in_valid && in_ready.
//   in_ready depends only on registered state and is low for the whole drain.
//   in_valid/in_row seen while in_ready is low are ignored.
//
// Ports:
//   clk, nrst     clock; asynchronous active-low reset
//   in_valid      row beat present
//   in_row        row elements, lane-indexed
//   in_ready      block accepts a beat this cycle (state != DRAIN)
//   out_valid     per-lane element valid
//   out_data      per-lane skewed element
//   tile_start    one-cycle pulse, the cycle after a tile's first beat
//   tile_done     one-cycle pulse, with the tile's last element on the last lane
//   busy          state != IDLE
//   dbg_state     current FSM state (IDLE=0, FILL=1, DRAIN=2)
//
// Configuration macro:
//   MATRIX_SKEW_ZERO_FILL_EN
//     When defined, out_data[i] reads 0 whenever out_valid[i] is 0.
//     When undefined, invalid lanes carry stale chain data.
// ---------------------------------------------------------------------------
module matrix_skew_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARALLEL_NUM = 8,
  parameter int INTER_NUM    = 8,
  parameter int CNT_WIDTH    = $clog2(INTER_NUM + 1),
  parameter int DRN_WIDTH    = $clog2(PARALLEL_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   in_valid,
  input  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] in_row,
  output logic                                   in_ready,
  output logic [PARALLEL_NUM-1:0]                out_valid,
  output logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] out_data,
  output logic                                   tile_start,
  output logic                                   tile_done,
  output logic                                   busy,
  output logic [1:0]                             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(INTER_NUM - 1);
  localparam logic [DRN_WIDTH-1:0] LAST_DRN  = DRN_WIDTH'(PARALLEL_NUM - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DRN_WIDTH-1:0]   drn_q, drn_d;
  logic                   tile_start_q, tile_start_d;
  logic                   tile_done_q, tile_done_d;
  logic                   accept;

  // The accepted row is registered once before entering the per-lane chains.
  // This makes lane i show a beat accepted at edge k in the cycle after
  // edge k+1+i.
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] row_q, row_d;
  logic                                    row_vld_q, row_vld_d;

  assign in_ready  = (state_q != DRAIN);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Tile framing FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drn_d        = drn_q;
    tile_start_d = 1'b0;
    tile_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          tile_start_d = 1'b1;
          drn_d        = '0;
          if (INTER_NUM == 1) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DRAIN;
            cnt_d   = '0;
            drn_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        drn_d = drn_q + DRN_WIDTH'(1);
        // The last element reaches the final lane register on the edge that
        // ends the drain, so tile_done lines up with it.
        if (drn_q == LAST_DRN) begin
          state_d     = IDLE;
          drn_d       = '0;
          tile_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        drn_d   = '0;
      end
    endcase
  end

  always_comb begin
    row_vld_d = accept;
    row_d     = accept ? in_row : row_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drn_q        <= '0;
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
      row_q        <= '0;
      row_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      tile_start_q <= tile_start_d;
      tile_done_q  <= tile_done_d;
      row_q        <= row_d;
      row_vld_q    <= row_vld_d;
    end
  end

  assign tile_start = tile_start_q;
  assign tile_done  = tile_done_q;

  // -------------------------------------------------------------------------
  // Skew chains
  //
  // Lane i is i+1 registers deep. The chains shift every cycle, so a cycle
  // without an accepted beat travels down as a bubble.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < PARALLEL_NUM; i++) begin : g_lane
    logic [i:0][DATA_WIDTH-1:0] dat_q, dat_d;
    logic [i:0]                 vld_q, vld_d;

    always_comb begin
      dat_d    = dat_q;
      vld_d    = vld_q;
      dat_d[0] = row_q[i];
      vld_d[0] = row_vld_q;
      for (int s = 1; s <= i; s++) begin
        dat_d[s] = dat_q[s-1];
        vld_d[s] = vld_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign out_valid[i] = vld_q[i];
`ifdef MATRIX_SKEW_ZERO_FILL_EN
    assign out_data[i] = vld_q[i] ? dat_q[i] : '0;
`else
    assign out_data[i] = dat_q[i];
`endif
  end

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// ---------------------------------------------------------------------------
// Testbench for matrix_skew_feeder.
//
// u_dut  : default parameters (8 lanes, 8-beat tiles).
// u_dut1 : 4 lanes with single-beat tiles.
//
// The reference model describes u_dut in terms of the tile schedule only:
//   - accepted beats are kept in per-cycle arrays;
//   - lane i at cycle n shows the beat accepted at edge n-1-i;
//   - after the last beat of a tile (edge k), in_ready is low in cycles
//     k..k+P-1 and tile_done is expected in cycle k+P.
// ---------------------------------------------------------------------------
module tb_matrix_skew_feeder;

  localparam int DW   = 8;
  localparam int P    = 8;
  localparam int I    = 8;
  localparam int P1   = 4;
  localparam int MAXC = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic                   in_valid;
  logic [P-1:0][DW-1:0]   in_row;
  logic                   in_ready;
  logic [P-1:0]           out_valid;
  logic [P-1:0][DW-1:0]   out_data;
  logic                   tile_start;
  logic                   tile_done;
  logic                   busy;
  logic [1:0]             dbg_state;

  matrix_skew_feeder #(
    .DATA_WIDTH(DW), .PARALLEL_NUM(P), .INTER_NUM(I)
  ) u_dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_row(in_row),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .tile_start(tile_start), .tile_done(tile_done), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (INTER_NUM = 1, PARALLEL_NUM = 4) ----------------
  logic                   v1;
  logic [P1-1:0][DW-1:0]  row1;
  logic                   in_ready1;
  logic [P1-1:0]          out_valid1;
  logic [P1-1:0][DW-1:0]  out_data1;
  logic                   tile_start1;
  logic                   tile_done1;
  logic                   busy1;
  logic [1:0]             dbg_state1;

  matrix_skew_feeder #(
    .DATA_WIDTH(DW), .PARALLEL_NUM(P1), .INTER_NUM(1)
  ) u_dut1 (
    .clk(clk), .nrst(nrst), .in_valid(v1), .in_row(row1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .tile_start(tile_start1), .tile_done(tile_done1), .busy(busy1),
    .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;            // current cycle index = number of edges since reset release
  int beats;          // beats accepted so far in the current tile
  int ds;             // edge of the most recent tile-ending beat, -1 if none

  bit               acc_v    [MAXC];
  logic [P*DW-1:0]  acc_row  [MAXC];
  bit               exp_start[MAXC];
  bit               exp_done [MAXC];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic bit m_in_drain(input int c);
    return (ds >= 0) && (c >= ds) && (c <= ds + P - 1);
  endfunction

  task automatic model_reset();
    cyc   = 0;
    beats = 0;
    ds    = -1;
    for (int c = 0; c < MAXC; c++) begin
      acc_v[c]     = 1'b0;
      acc_row[c]   = '0;
      exp_start[c] = 1'b0;
      exp_done[c]  = 1'b0;
    end
  endtask

  function automatic logic [P*DW-1:0] rand_row();
    logic [P*DW-1:0] r;
    for (int l = 0; l < P; l++) r[l*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Compare every u_dut output against the model for the current cycle.
  task automatic check_cycle();
    logic [P-1:0] ev;
    logic [P*DW-1:0] row;
    bit exp_busy;
    int e;
    for (int l = 0; l < P; l++) begin
      e = cyc - 1 - l;
      ev[l] = (e >= 0) && acc_v[e];
      if (ev[l]) begin
        row = acc_row[e];
        check_eq($sformatf("lane%0d_data", l), 64'(out_data[l]), 64'(row[l*DW +: DW]));
      end
`ifdef MATRIX_SKEW_ZERO_FILL_EN
      else begin
        check_eq($sformatf("lane%0d_zero", l), 64'(out_data[l]), 64'd0);
      end
`endif
    end
    exp_busy = (beats > 0) || m_in_drain(cyc);
    check_eq("out_valid",  64'(out_valid),  64'(ev));
    check_eq("in_ready",   64'(in_ready),   64'(!m_in_drain(cyc)));
    check_eq("tile_start", 64'(tile_start), 64'(exp_start[cyc]));
    check_eq("tile_done",  64'(tile_done),  64'(exp_done[cyc]));
    check_eq("busy",       64'(busy),       64'(exp_busy));
    check_eq("dbg_idle",   64'(dbg_state == 2'd0), 64'(!exp_busy));
  endtask

  // One clock of u_dut: drive, let the edge happen, update model, compare.
  task automatic step(input bit v, input logic [P*DW-1:0] row);
    bit acc;
    in_valid = v;
    in_row   = row;
    acc = v && !m_in_drain(cyc);
    @(posedge clk);
    cyc++;
    if (acc) begin
      acc_v[cyc]   = 1'b1;
      acc_row[cyc] = row;
      if (beats == 0) exp_start[cyc] = 1'b1;
      beats++;
      if (beats == I) begin
        ds = cyc;
        exp_done[cyc + P] = 1'b1;
        beats = 0;
      end
    end
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, rand_row());
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check_eq({tag, "_out_data"},   64'(out_data),   64'd0);
    check_eq({tag, "_in_ready"},   64'(in_ready),   64'd1);
    check_eq({tag, "_tile_start"}, 64'(tile_start), 64'd0);
    check_eq({tag, "_tile_done"},  64'(tile_done),  64'd0);
    check_eq({tag, "_busy"},       64'(busy),       64'd0);
    check_eq({tag, "_out_valid1"}, 64'(out_valid1), 64'd0);
    check_eq({tag, "_out_data1"},  64'(out_data1),  64'd0);
    check_eq({tag, "_busy1"},      64'(busy1),      64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [P*DW-1:0] r;
    logic [P1-1:0]   ev1;

    nrst     = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    v1       = 1'b0;
    row1     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    nrst = 1'b1;
    check_cycle();

    // Back-to-back tile: lane i of row r carries 8r+i.
    for (int b = 0; b < I; b++) begin
      for (int l = 0; l < P; l++) r[l*DW +: DW] = DW'(P*b + l);
      step(1'b1, r);
    end
    idle(12);

    // Same tile with a 3-cycle gap after beat 4.
    for (int b = 0; b < I; b++) begin
      if (b == 4) idle(3);
      for (int l = 0; l < P; l++) r[l*DW +: DW] = DW'(P*b + l);
      step(1'b1, r);
    end
    idle(12);

    // in_valid held through drains with changing data.
    for (int c = 0; c < 45; c++) step(1'b1, rand_row());
    idle(20);

    // Random traffic.
    for (int c = 0; c < 400; c++) step($urandom_range(0, 99) < 70, rand_row());
    idle(20);

    // Reset in the middle of a tile, after beat 5.
    for (int b = 0; b < 5; b++) step(1'b1, rand_row());
    @(negedge clk);
    nrst     = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    check_cycle();
    for (int b = 0; b < I; b++) step(1'b1, rand_row());
    idle(12);

    // Single-beat tiles on 4 lanes: lane i shows i+1 at cycle k+1+i.
    // in_valid stays high through the drain and must be ignored.
    in_valid = 1'b0;
    v1       = 1'b1;
    row1     = {8'd4, 8'd3, 8'd2, 8'd1};
    @(posedge clk);
    #1;
    for (int t = 0; t < 8; t++) begin
      ev1 = (t >= 1 && t <= 4) ? P1'(1 << (t - 1)) : '0;
      check_eq("u1_out_valid",  64'(out_valid1),  64'(ev1));
      if (t >= 1 && t <= 4) begin
        check_eq($sformatf("u1_lane%0d_data", t - 1), 64'(out_data1[t-1]), 64'(t));
      end
      check_eq("u1_in_ready",   64'(in_ready1),   64'(t >= 4));
      check_eq("u1_tile_start", 64'(tile_start1), 64'(t == 0));
      check_eq("u1_tile_done",  64'(tile_done1),  64'(t == 4));
      check_eq("u1_busy",       64'(busy1),       64'(t <= 3));
      if (t < 4) begin
        v1   = 1'b1;
        row1 = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
      end else begin
        v1 = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
